// File: rtl/mips_seq_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: quotient to LO, remainder to HI.
// Optional macro DIV_ZERO_FAST_EN: early-out on a zero divisor with a div_zero flag.
module mips_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
`ifdef DIV_ZERO_FAST_EN
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
`else
  output logic [WIDTH-1:0] remainder
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t           state;
  logic             sgn;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    count;
  logic             neg_q;
  logic             neg_r;
`ifdef DIV_ZERO_FAST_EN
  logic             zero_seen;
`endif

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial_lo;
  logic             trial_ge;

  always_comb begin
    dvd_neg  = sgn & dvd[WIDTH-1];
    dvs_neg  = sgn & dvs[WIDTH-1];
    dvd_mag  = dvd_neg ? -dvd : dvd;
    dvs_mag  = dvs_neg ? -dvs : dvs;
    shifted  = {rem, quo[WIDTH-1]};
    // Carry-out of the shift counts toward the compare, so the trial is WIDTH+1 wide.
    trial_ge = shifted[WIDTH] | (shifted[WIDTH-1:0] >= dvs);
    trial_lo = shifted[WIDTH-1:0] - dvs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sgn       <= 1'b0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      quo       <= '0;
      count     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_FAST_EN
      zero_seen <= 1'b0;
      div_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sgn   <= is_signed;
            dvd   <= dividend;
            dvs   <= divisor;
            busy  <= 1'b1;
            state <= PREP;
`ifdef DIV_ZERO_FAST_EN
            div_zero <= 1'b0;
`endif
          end
        end
        PREP: begin
          neg_q <= dvd_neg ^ dvs_neg;
          neg_r <= dvd_neg;
          dvs   <= dvs_mag;
          quo   <= dvd_mag;
          rem   <= '0;
          count <= '0;
          state <= ITER;
`ifdef DIV_ZERO_FAST_EN
          zero_seen <= 1'b0;
          // Preload the magnitude results so FIX applies the usual sign correction.
          if (dvs == '0) begin
            quo       <= '1;
            rem       <= dvd_mag;
            zero_seen <= 1'b1;
            state     <= FIX;
          end
`endif
        end
        ITER: begin
          if (trial_ge) begin
            rem <= trial_lo;
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          quotient  <= neg_q ? -quo : quo;
          remainder <= neg_r ? -rem : rem;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
`ifdef DIV_ZERO_FAST_EN
          div_zero  <= zero_seen;
`endif
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_seq_divider.sv
// Directed self-checking bench for mips_seq_divider (WIDTH=32): vector table plus
// handshake, ignored-start and mid-operation reset sequences.
module tb_mips_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
`ifdef DIV_ZERO_FAST_EN
  logic        div_zero;
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 34;
`endif

  int errors = 0;
  int checks = 0;

  mips_seq_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
`ifdef DIV_ZERO_FAST_EN
    .remainder (remainder),
    .div_zero  (div_zero)
`else
    .remainder (remainder)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts an operation, scrambles the inputs after the sampling edge, then
  // checks latency, busy profile, results and the single-cycle done pulse.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input int lat,
                        input string tag);
    int  k;
    bit  busy_ok;
    k = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; is_signed = ~s; dividend = $urandom; divisor = $urandom;
    if (busy !== 1'b1) busy_ok = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        k = i;
        break;
      end
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
    end
    chk({tag, " latency"}, k, lat);
    chk({tag, " busy during op"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    chk({tag, " quotient"}, quotient, q);
    chk({tag, " remainder"}, remainder, r);
`ifdef DIV_ZERO_FAST_EN
    chk({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, (b == 32'd0)});
`endif
    @(posedge clk); #1;
    chk({tag, " done single cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          34};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   34};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          34};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          34};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          34};
    vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          ZLAT};
    vecs[6]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'd1,          32'hFFFFFFFB,   ZLAT};
    vecs[7]  = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          ZLAT};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          34};
    vecs[9]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   34};
    vecs[10] = '{1'b0, 32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          34};
    vecs[11] = '{1'b0, 32'd7,          32'd100,        32'd0,          32'd7,          34};

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 12; v++)
      run_op(vecs[v].s, vecs[v].a, vecs[v].b, vecs[v].q, vecs[v].r, vecs[v].lat,
             $sformatf("vec%0d", v));

    // Start pulses during the op and during the done cycle must be ignored.
    begin
      int  k;
      bit  stray;
      k = 0;
      stray = 1'b0;
      @(negedge clk);
      is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int i = 1; i <= 60; i++) begin
        @(posedge clk); #1;
        if (i == 4) begin
          dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b1; start = 1'b1;
        end else if (i == 5) begin
          start = 1'b0;
        end
        if (done === 1'b1) begin
          k = i;
          break;
        end
      end
      chk("ignore latency", k, 34);
      chk("ignore quotient", quotient, 32'd14);
      chk("ignore remainder", remainder, 32'd2);
      dividend = 32'd50; divisor = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (busy !== 1'b0 || done !== 1'b0) stray = 1'b1;
        @(posedge clk); #1;
      end
      chk("done-cycle start ignored", {31'd0, stray}, 32'd0);
      chk("done-cycle start results held", quotient, 32'd14);
    end
    run_op(1'b0, 32'd9, 32'd2, 32'd4, 32'd1, 34, "back2back");

    // Asynchronous reset in mid-operation aborts without a done pulse.
    begin
      bit pulsed;
      pulsed = 1'b0;
      @(negedge clk);
      is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort done", {31'd0, done}, 32'd0);
      chk("abort quotient", quotient, 32'd0);
      chk("abort remainder", remainder, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (done !== 1'b0) pulsed = 1'b1;
      end
      chk("abort no done pulse", {31'd0, pulsed}, 32'd0);
    end
    run_op(1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 34, "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
